// File: rtl/stb.sv
// Store buffer: circular FIFO of committed word stores with youngest-entry
// merging, in-order drain to the memory arbiter and byte-wise load forwarding.
module stb #(
  parameter int unsigned STB_LINES = 4,
  parameter int unsigned PA_WIDTH  = 32,
  parameter int unsigned REG_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_store_valid,
  input  logic [PA_WIDTH-1:0]            i_store_addr,
  input  logic [REG_WIDTH-1:0]           i_store_data,
  input  logic [REG_WIDTH/8-1:0]         i_store_mask,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(STB_LINES):0]     o_count,
  input  logic [PA_WIDTH-1:0]            i_lookup_addr,
  output logic                           o_fwd_hit,
  output logic [REG_WIDTH-1:0]           o_fwd_data,
  output logic [REG_WIDTH/8-1:0]         o_fwd_mask,
  output logic                           o_mem_enable,
  output logic [PA_WIDTH-1:0]            o_mem_addr,
  output logic [REG_WIDTH-1:0]           o_mem_data,
  output logic [REG_WIDTH/8-1:0]         o_mem_mask,
  input  logic                           i_mem_grant
);

  localparam int unsigned MASK_W = REG_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(STB_LINES);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned OFF_W  = $clog2(MASK_W);

  logic                 r_valid [STB_LINES];
  logic [PA_WIDTH-1:0]  r_addr  [STB_LINES];
  logic [REG_WIDTH-1:0] r_data  [STB_LINES];
  logic [MASK_W-1:0]    r_mask  [STB_LINES];
  logic [IDX_W-1:0]     r_head;
  logic [IDX_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic [IDX_W-1:0]     w_tail_m1;
  logic [PA_WIDTH-1:0]  w_st_aligned;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_merge;
  logic                 w_push;
  logic                 w_pop;
  logic [REG_WIDTH-1:0] w_merge_data;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_fwd_hit;
  logic [REG_WIDTH-1:0] w_fwd_data;
  logic [MASK_W-1:0]    w_fwd_mask;

  // Control decode: merge only into the youngest entry when it is not the head
  assign w_tail_m1    = r_tail - IDX_W'(1);
  assign w_st_aligned = {i_store_addr[PA_WIDTH-1:OFF_W], OFF_W'(0)};
  assign w_full       = (r_count == CNT_W'(STB_LINES));
  assign w_empty      = (r_count == CNT_W'(0));
  assign w_merge      = i_store_valid && (r_count >= CNT_W'(2)) && r_valid[w_tail_m1] &&
                        (r_addr[w_tail_m1][PA_WIDTH-1:OFF_W] == i_store_addr[PA_WIDTH-1:OFF_W]);
  assign w_push       = i_store_valid && !w_merge && !w_full;
  assign w_pop        = !w_empty && i_mem_grant;

  // Byte-merge of the incoming store over the youngest entry's data
  always_comb begin
    w_merge_data = r_data[w_tail_m1];
    for (int b = 0; b < MASK_W; b++) begin
      if (i_store_mask[b]) begin
        w_merge_data[8*b +: 8] = i_store_data[8*b +: 8];
      end
    end
  end

  // Entry storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STB_LINES; i++) begin
        r_valid[i] <= 1'b0;
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
        r_mask[i]  <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_merge) begin
        r_data[w_tail_m1] <= w_merge_data;
        r_mask[w_tail_m1] <= r_mask[w_tail_m1] | i_store_mask;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= w_st_aligned;
        r_data[r_tail]  <= i_store_data;
        r_mask[r_tail]  <= i_store_mask;
        r_tail          <= r_tail + IDX_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + IDX_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Forwarding: walk entries oldest to youngest so younger bytes win
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_mask = '0;
    w_fwd_data = '0;
    w_idx      = r_head;
    for (int k = 0; k < STB_LINES; k++) begin
      w_idx = r_head + IDX_W'(k);
      if (r_valid[w_idx] &&
          (r_addr[w_idx][PA_WIDTH-1:OFF_W] == i_lookup_addr[PA_WIDTH-1:OFF_W])) begin
        w_fwd_hit  = 1'b1;
        w_fwd_mask = w_fwd_mask | r_mask[w_idx];
        for (int b = 0; b < MASK_W; b++) begin
          if (r_mask[w_idx][b]) begin
            w_fwd_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign o_full       = w_full;
  assign o_empty      = w_empty;
  assign o_count      = r_count;
  assign o_fwd_hit    = w_fwd_hit;
  assign o_fwd_data   = w_fwd_data;
  assign o_fwd_mask   = w_fwd_mask;
  assign o_mem_enable = !w_empty;
  assign o_mem_addr   = w_empty ? '0 : r_addr[r_head];
  assign o_mem_data   = w_empty ? '0 : r_data[r_head];
  assign o_mem_mask   = w_empty ? '0 : r_mask[r_head];

endmodule

// File: tb/tb_stb.sv
// Self-checking bench for stb: drain scoreboard plus forwarding model.
module tb_stb;

  localparam int unsigned LINES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_store_valid;
  logic [31:0] i_store_addr;
  logic [31:0] i_store_data;
  logic [3:0]  i_store_mask;
  logic        o_full;
  logic        o_empty;
  logic [2:0]  o_count;
  logic [31:0] i_lookup_addr;
  logic        o_fwd_hit;
  logic [31:0] o_fwd_data;
  logic [3:0]  o_fwd_mask;
  logic        o_mem_enable;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic [3:0]  o_mem_mask;
  logic        i_mem_grant;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  ent_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  stb #(.STB_LINES(LINES), .PA_WIDTH(32), .REG_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_store_valid(i_store_valid), .i_store_addr(i_store_addr),
    .i_store_data(i_store_data), .i_store_mask(i_store_mask),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .i_lookup_addr(i_lookup_addr),
    .o_fwd_hit(o_fwd_hit), .o_fwd_data(o_fwd_data), .o_fwd_mask(o_fwd_mask),
    .o_mem_enable(o_mem_enable), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .o_mem_mask(o_mem_mask),
    .i_mem_grant(i_mem_grant)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected forwarding result from the scoreboard contents (oldest first)
  task automatic check_fwd();
    logic        hit;
    logic [3:0]  msk;
    logic [31:0] dat;
    hit = 1'b0; msk = '0; dat = '0;
    foreach (sb[i]) begin
      if (sb[i].a[31:2] == i_lookup_addr[31:2]) begin
        hit = 1'b1;
        msk = msk | sb[i].m;
        for (int b = 0; b < 4; b++)
          if (sb[i].m[b]) dat[8*b +: 8] = sb[i].d[8*b +: 8];
      end
    end
    check_eq("fwd_hit", 64'(o_fwd_hit), 64'(hit));
    check_eq("fwd_mask", 64'(o_fwd_mask), 64'(msk));
    check_eq("fwd_data", 64'(o_fwd_data), 64'(dat));
  endtask

  // One clock: drive, check head/forwarding, clock, update model, check occupancy
  task automatic step(input bit sv, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input bit g);
    int   n0;
    bit   mrg;
    ent_t e;
    i_store_valid = sv; i_store_addr = a; i_store_data = d; i_store_mask = m;
    i_mem_grant = g;
    #1;
    check_eq("mem_en", 64'(o_mem_enable), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check_eq("drain_addr", 64'(o_mem_addr), 64'(sb[0].a));
      check_eq("drain_data", 64'(o_mem_data), 64'(sb[0].d));
      check_eq("drain_mask", 64'(o_mem_mask), 64'(sb[0].m));
    end
    check_fwd();
    @(posedge clk);
    n0  = sb.size();
    mrg = sv && n0 >= 2 && sb[n0-1].a[31:2] == a[31:2];
    if (mrg) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) sb[n0-1].d[8*b +: 8] = d[8*b +: 8];
      sb[n0-1].m = sb[n0-1].m | m;
    end
    if (g && n0 > 0) void'(sb.pop_front());
    if (sv && !mrg && n0 < LINES) begin
      e.a = {a[31:2], 2'b00}; e.d = d; e.m = m;
      sb.push_back(e);
    end
    #1;
    i_store_valid = 1'b0; i_mem_grant = 1'b0;
    check_eq("count", 64'(o_count), 64'(sb.size()));
    check_eq("full", 64'(o_full), 64'(sb.size() == LINES));
    check_eq("empty", 64'(o_empty), 64'(sb.size() == 0));
  endtask

  task automatic idle_grant();
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; i_store_valid = 1'b0; i_store_addr = '0; i_store_data = '0;
    i_store_mask = '0; i_lookup_addr = '0; i_mem_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_empty", 64'(o_empty), 64'd1);
    check_eq("rst_full", 64'(o_full), 64'd0);
    check_eq("rst_count", 64'(o_count), 64'd0);
    check_eq("rst_mem_en", 64'(o_mem_enable), 64'd0);
    check_eq("rst_fwd_hit", 64'(o_fwd_hit), 64'd0);
    check_eq("rst_fwd_mask", 64'(o_fwd_mask), 64'd0);
    check_eq("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    check_eq("rst_mem_data", 64'(o_mem_data), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Single store then drain
    step(1'b1, 32'h100, 32'hAABBCCDD, 4'hF, 1'b0);
    check_eq("t1_count", 64'(o_count), 64'd1);
    check_eq("t1_mem_en", 64'(o_mem_enable), 64'd1);
    check_eq("t1_addr", 64'(o_mem_addr), 64'h100);
    check_eq("t1_data", 64'(o_mem_data), 64'hAABBCCDD);
    idle_grant();
    check_eq("t1_empty", 64'(o_empty), 64'd1);

    // Fill, overflow store ignored, drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 32'(4*i), 32'hD0 + 32'(i), 4'hF, 1'b0);
    check_eq("t2_full", 64'(o_full), 64'd1);
    step(1'b1, 32'h20, 32'hDEAD, 4'hF, 1'b0);
    check_eq("t2_count", 64'(o_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t2_order", 64'(o_mem_addr), 64'h10 + 64'(4*i));
      idle_grant();
    end
    check_eq("t2_empty", 64'(o_empty), 64'd1);

    // Merge into youngest entry
    step(1'b1, 32'h40, 32'h11111111, 4'hF, 1'b0);
    step(1'b1, 32'h44, 32'h000000EE, 4'h1, 1'b0);
    step(1'b1, 32'h44, 32'h0000DD00, 4'h2, 1'b0);
    check_eq("t3_count", 64'(o_count), 64'd2);
    i_lookup_addr = 32'h44; #1;
    check_eq("t3_fwd_data", 64'(o_fwd_data), 64'h0000DDEE);
    check_eq("t3_fwd_mask", 64'(o_fwd_mask), 64'h3);
    idle_grant();
    check_eq("t3_tail_data", 64'(o_mem_data), 64'h0000DDEE);
    check_eq("t3_tail_mask", 64'(o_mem_mask), 64'h3);
    idle_grant();

    // No merge into head; forwarding picks youngest byte
    step(1'b1, 32'h80, 32'h11223344, 4'hF, 1'b0);
    step(1'b1, 32'h80, 32'h000000FF, 4'h1, 1'b0);
    check_eq("t4_count", 64'(o_count), 64'd2);
    i_lookup_addr = 32'h80; #1;
    check_eq("t4_hit", 64'(o_fwd_hit), 64'd1);
    check_eq("t4_mask", 64'(o_fwd_mask), 64'hF);
    check_eq("t4_data", 64'(o_fwd_data), 64'h112233FF);
    i_lookup_addr = 32'h84; #1;
    check_eq("t4_miss", 64'(o_fwd_hit), 64'd0);
    idle_grant();
    idle_grant();

    // Full with simultaneous store and grant: pop only
    for (int i = 0; i < 4; i++) step(1'b1, 32'h200 + 32'(4*i), 32'hC0 + 32'(i), 4'hF, 1'b0);
    step(1'b1, 32'h210, 32'h12345678, 4'hF, 1'b1);
    check_eq("t5_count3", 64'(o_count), 64'd3);
    step(1'b1, 32'h210, 32'h12345678, 4'hF, 1'b0);
    check_eq("t5_count4", 64'(o_count), 64'd4);
    repeat (4) idle_grant();

    // Reset mid-drain discards everything
    step(1'b1, 32'h300, 32'h1, 4'hF, 1'b0);
    step(1'b1, 32'h304, 32'h2, 4'hF, 1'b0);
    step(1'b1, 32'h308, 32'h3, 4'hF, 1'b0);
    idle_grant();
    rst = 1'b0; #1;
    check_eq("t6_count", 64'(o_count), 64'd0);
    check_eq("t6_mem_en", 64'(o_mem_enable), 64'd0);
    sb.delete();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    repeat (3) idle_grant();

    // Randomised traffic on a small address set to exercise merging
    for (int i = 0; i < 80; i++) begin
      i_lookup_addr = 32'h400 + 32'(4 * $urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), 32'h400 + 32'(4 * $urandom_range(0, 3)), $urandom,
           4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 8 && sb.size() != 0; i++) idle_grant();
    check_eq("final_empty", 64'(o_empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
